// File: rtl/faller_if.sv
// Falling-object bus between faller and the stacker/game controller; the master modport belongs to faller.
// There is no backpressure. start is a level input, collision is a pulse, and every output is a registered level.
interface faller_if;
    logic       start;
    logic       collision;
    logic [9:0] fall_x;
    logic [9:0] fall_y;
    logic [1:0] fall_color;
    logic       active;
    logic [7:0] caught_count;
    logic [1:0] lives;
    logic       game_over;

    modport master (
        input  start, collision,
        output fall_x, fall_y, fall_color, active, caught_count, lives, game_over
    );

    modport slave (
        output start, collision,
        input  fall_x, fall_y, fall_color, active, caught_count, lives, game_over
    );
endinterface

// File: rtl/faller.sv
// Spawns and drops the falling object, counts catches and lives. A catch shows active low on the next cycle and a new object 2 cycles later.
// There is no backpressure: collision is sampled only in FALL and start only in IDLE/OVER; all outputs are registered.
module faller #(
    parameter int X_MAX         = 620,
    parameter int FLOOR_Y       = 460,
    parameter int DIV_WIDTH     = 18,
    parameter int LIVES         = 3,
    parameter int MAX_STEP      = 4,
    parameter int SPEEDUP_EVERY = 5
) (
    input logic      clk,
    input logic      rst,
    faller_if.master fall_bus
);
    typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_FALL, S_CAUGHT, S_MISSED, S_OVER} state_t;

    localparam logic [9:0]  X_LIM      = 10'(X_MAX);
    localparam logic [9:0]  X_WRAP     = 10'(X_MAX + 1);
    localparam logic [10:0] FLOOR11    = 11'(FLOOR_Y);
    localparam logic [9:0]  FLOOR10    = 10'(FLOOR_Y);
    localparam logic [2:0]  STEP_MAX   = 3'(MAX_STEP);
    localparam logic [7:0]  CATCH_N    = 8'(SPEEDUP_EVERY);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

    state_t               r_state;
    logic [15:0]          r_lfsr;
    logic [DIV_WIDTH-1:0] r_div;
    logic [9:0]           r_fall_x;
    logic [9:0]           r_fall_y;
    logic [1:0]           r_fall_color;
    logic                 r_active;
    logic [7:0]           r_caught;
    logic [1:0]           r_lives;
    logic                 r_game_over;
    logic [2:0]           r_step;
    logic [7:0]           r_catch_mod;

    logic                 w_lfsr_fb;
    logic [9:0]           w_rand;
    logic [9:0]           w_spawn_x;
    logic [1:0]           w_spawn_color;
    logic                 w_tick;
    logic [10:0]          w_y_next;
    logic [7:0]           w_catch_mod_inc;

    assign w_lfsr_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_rand          = r_lfsr[9:0];
    // X_MAX >= 511 means that a single subtraction always folds an out-of-range value back into 0..X_MAX.
    assign w_spawn_x       = (w_rand <= X_LIM) ? w_rand : (w_rand - X_WRAP);
    assign w_spawn_color   = (r_lfsr[11:10] == 2'b00) ? 2'b01 : r_lfsr[11:10];
    assign w_tick          = (r_div == '0);
    assign w_y_next        = {1'b0, r_fall_y} + {8'b0, r_step};
    assign w_catch_mod_inc = r_catch_mod + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_lfsr       <= 16'hACE1;
            r_div        <= '0;
            r_fall_x     <= 10'd0;
            r_fall_y     <= 10'd0;
            r_fall_color <= 2'b01;
            r_active     <= 1'b0;
            r_caught     <= 8'd0;
            r_lives      <= LIVES_INIT;
            r_game_over  <= 1'b0;
            r_step       <= 3'd1;
            r_catch_mod  <= 8'd0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            r_div  <= r_div + 1'b1;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (fall_bus.start) begin
                        r_state     <= S_SPAWN;
                        r_lives     <= LIVES_INIT;
                        r_caught    <= 8'd0;
                        r_step      <= 3'd1;
                        r_catch_mod <= 8'd0;
                        r_game_over <= 1'b0;
                    end
                end
                S_SPAWN: begin
                    r_fall_x     <= w_spawn_x;
                    r_fall_y     <= 10'd0;
                    r_fall_color <= w_spawn_color;
                    r_active     <= 1'b1;
                    r_state      <= S_FALL;
                end
                S_FALL: begin
                    // If a catch and a floor-reaching tick land on the same cycle, the catch takes priority.
                    if (fall_bus.collision) begin
                        r_active <= 1'b0;
                        r_state  <= S_CAUGHT;
                    end else if (w_tick) begin
                        if (w_y_next >= FLOOR11) begin
                            r_fall_y <= FLOOR10;
                            r_active <= 1'b0;
                            r_state  <= S_MISSED;
                        end else begin
                            r_fall_y <= w_y_next[9:0];
                        end
                    end
                end
                S_CAUGHT: begin
                    if (r_caught != 8'hFF) begin
                        r_caught <= r_caught + 8'd1;
                    end
                    if (w_catch_mod_inc >= CATCH_N) begin
                        r_catch_mod <= 8'd0;
                        if (r_step < STEP_MAX) begin
                            r_step <= r_step + 3'd1;
                        end
                    end else begin
                        r_catch_mod <= w_catch_mod_inc;
                    end
                    r_state <= S_SPAWN;
                end
                S_MISSED: begin
                    r_lives <= r_lives - 2'd1;
                    if (r_lives == 2'd1) begin
                        r_game_over <= 1'b1;
                        r_state     <= S_OVER;
                    end else begin
                        r_state <= S_SPAWN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fall_bus.fall_x       = r_fall_x;
    assign fall_bus.fall_y       = r_fall_y;
    assign fall_bus.fall_color   = r_fall_color;
    assign fall_bus.active       = r_active;
    assign fall_bus.caught_count = r_caught;
    assign fall_bus.lives        = r_lives;
    assign fall_bus.game_over    = r_game_over;
endmodule

// File: tb/tb_faller.sv
// Directed bench for faller with a 4-clock fall tick: spawn, miss/game-over, catches and speed-up, catch-vs-floor priority, reset, x folding.
`timescale 1ns/1ps
module tb_faller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    faller_if bus();

    faller #(.DIV_WIDTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .fall_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_y(input logic [9:0] target, input int limit);
        int k = 0;
        while (bus.fall_y !== target && k < limit) begin
            step(1);
            k++;
        end
        if (bus.fall_y !== target) chk("wait_y_timeout", bus.fall_y, target);
    endtask

    task automatic wait_change(output int dt, output logic [9:0] ny);
        logic [9:0] prev = bus.fall_y;
        dt = 0;
        while (bus.fall_y === prev && dt < 64) begin
            step(1);
            dt++;
        end
        ny = bus.fall_y;
    endtask

    task automatic do_catch();
        bus.collision = 1'b1;
        step(1);
        bus.collision = 1'b0;
        step(2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_x"},      bus.fall_x, 0);
        chk({tag, "_y"},      bus.fall_y, 0);
        chk({tag, "_color"},  bus.fall_color, 1);
        chk({tag, "_active"}, bus.active, 0);
        chk({tag, "_caught"}, bus.caught_count, 0);
        chk({tag, "_lives"},  bus.lives, 3);
        chk({tag, "_over"},   bus.game_over, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         dt;
        int         k;
        logic [9:0] ny;
        bus.start     = 1'b0;
        bus.collision = 1'b0;
        #23;
        chk_reset_outputs("rst");
        rst = 1'b1;
        step(3);
        chk("idle_active", bus.active, 0);

        // Start a game: the object first appears in FALL at the top with legal x and colour.
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("spawn_active", bus.active, 0);
        step(1);
        chk("fall_active", bus.active, 1);
        chk("fall_y0", bus.fall_y, 0);
        chk("fall_x_range", (bus.fall_x <= 10'd620), 1);
        chk("fall_color_nz", (bus.fall_color != 2'b00), 1);
        wait_change(dt, ny);
        chk("y_first_step", ny, 1);
        wait_change(dt, ny);
        chk("y_tick_period", dt, 4);
        chk("y_second_step", ny, 2);

        // Without a catch the object saturates at the floor and a life is lost.
        k = 0;
        while (bus.active && k < 3000) begin
            step(1);
            k++;
        end
        chk("miss_active", bus.active, 0);
        chk("miss_y_floor", bus.fall_y, 460);
        chk("miss_lives_pre", bus.lives, 3);
        step(1);
        chk("miss_lives_dec", bus.lives, 2);
        step(1);
        chk("respawn_active", bus.active, 1);
        chk("respawn_y0", bus.fall_y, 0);

        k = 0;
        while (!bus.game_over && k < 8000) begin
            step(1);
            k++;
        end
        chk("over_flag", bus.game_over, 1);
        chk("over_lives", bus.lives, 0);
        chk("over_active", bus.active, 0);
        chk("over_y_hold", bus.fall_y, 460);
        step(3);
        chk("over_stays", bus.game_over, 1);

        // Restart from OVER and catch at y=100.
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("restart_over_clr", bus.game_over, 0);
        chk("restart_lives", bus.lives, 3);
        chk("restart_caught", bus.caught_count, 0);
        step(1);
        chk("restart_active", bus.active, 1);
        wait_y(10'd100, 600);
        bus.collision = 1'b1;
        step(1);
        bus.collision = 1'b0;
        chk("catch_active_lo1", bus.active, 0);
        step(1);
        chk("catch_count1", bus.caught_count, 1);
        chk("catch_active_lo2", bus.active, 0);
        step(1);
        chk("catch_new_active", bus.active, 1);
        chk("catch_new_y0", bus.fall_y, 0);

        // Speed-up: step 2 after 5 catches, 4 after 15, still 4 after 20.
        repeat (4) do_catch();
        chk("catch_count5", bus.caught_count, 5);
        wait_change(dt, ny);
        chk("step2_first", ny, 2);
        wait_change(dt, ny);
        chk("step2_second", ny, 4);
        repeat (10) do_catch();
        chk("catch_count15", bus.caught_count, 15);
        wait_change(dt, ny);
        chk("step4_first", ny, 4);
        repeat (5) do_catch();
        chk("catch_count20", bus.caught_count, 20);
        wait_change(dt, ny);
        chk("step_sat_first", ny, 4);
        wait_change(dt, ny);
        chk("step_sat_second", ny, 8);

        // Drive collision on the same edge as the tick that would reach the floor (456 + 4).
        wait_y(10'd456, 600);
        step(3);
        bus.collision = 1'b1;
        step(1);
        bus.collision = 1'b0;
        chk("tie_y_held", bus.fall_y, 456);
        chk("tie_active", bus.active, 0);
        chk("tie_lives_pre", bus.lives, 3);
        step(1);
        chk("tie_caught", bus.caught_count, 21);
        chk("tie_lives", bus.lives, 3);
        step(1);

        // Assert reset mid-fall.
        wait_y(10'd200, 300);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        step(2);
        rst = 1'b1;
        step(10);
        chk("midrst_needs_start", bus.active, 0);

        // Force lfsr[9:0]=1000 with a 00 colour field: x folds to 379 and the colour becomes 01.
        force dut.r_lfsr = 16'h03E8;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(1);
        release dut.r_lfsr;
        chk("fold_x", bus.fall_x, 379);
        chk("fold_color", bus.fall_color, 1);
        chk("fold_active", bus.active, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
